// File: rtl/matrix_pkg.sv
// matrix_pkg: shared geometry, types and helpers for the LED matrix scanner.
//   MATRIX_ROWS / MATRIX_COLS : matrix geometry
//   row_t                     : row index type
//   scan_state_e              : scan FSM states
package matrix_pkg;

    localparam int unsigned MATRIX_ROWS = 8;
    localparam int unsigned MATRIX_COLS = 8;

    typedef logic [2:0] row_t;

    typedef enum logic [0:0] {
        SCAN  = 1'b0,
        BLANK = 1'b1
    } scan_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// scan_timer: phase cycle counter for the matrix scanner.
// Counts 0..i_last, then wraps to 0; o_tc flags the final cycle of a phase.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset (clears the count)
//   i_last : terminal count (phase length - 1), may change per phase
//   o_cnt  : current count
//   o_tc   : high on the last cycle of the phase
module scan_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (o_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/matrix_scan.sv
// matrix_scan: double-buffered 8x8 LED matrix row scanner.
// The CPU writes rows into a back buffer; the front buffer is shown by row
// scanning and is replaced by the back buffer only at a frame boundary.
// Optional macro MATRIX_SCAN_BLANK_EN inserts a dark BLANK phase after each row.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   wr_en       : write strobe, wr_addr/wr_data go to back[wr_addr]
//   swap_req    : request front <= back at the next frame boundary
//   swap_ack    : pulse on the first cycle the new frame is shown
//   frame_start : pulse on the first cycle of row 0
//   row         : active-low one-hot row select (FF = dark)
//   col         : column data for the selected row
//   low         : constant 0
module matrix_scan
    import matrix_pkg::*;
#(
    parameter int unsigned ROW_CYCLES   = 8192,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       frame_start,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       low
);

    localparam int unsigned CNT_W = $clog2(max_u(ROW_CYCLES, BLANK_CYCLES));
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_CYCLES - 1);
`ifdef MATRIX_SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

    logic [MATRIX_COLS-1:0] r_back  [MATRIX_ROWS];
    logic [MATRIX_COLS-1:0] r_front [MATRIX_ROWS];
    logic                   r_pending;
    logic                   r_ack_pend;
    scan_state_e            r_state;
    scan_state_e            w_state_d;
    row_t                   r_idx;
    row_t                   w_idx_d;

    logic [CNT_W-1:0]       w_last;
    logic [CNT_W-1:0]       w_cnt;
    logic                   w_tc;
    logic                   w_boundary;
    logic                   w_swap;

    logic [7:0]             w_row;
    logic [7:0]             w_col;
    logic                   w_fs;

    logic [7:0]             r_row;
    logic [7:0]             r_col;
    logic                   r_frame_start;
    logic                   r_swap_ack;

    scan_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_last (w_last),
        .o_cnt  (w_cnt),
        .o_tc   (w_tc)
    );

    // Next-state: phase sequencing and frame boundary detection.
    always_comb begin
        w_state_d  = r_state;
        w_idx_d    = r_idx;
        w_last     = ROW_LAST;
        w_boundary = 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
        case (r_state)
            SCAN: begin
                w_last = ROW_LAST;
                if (w_tc) begin
                    w_state_d = BLANK;
                end
            end
            BLANK: begin
                w_last = BLANK_LAST;
                if (w_tc) begin
                    w_state_d  = SCAN;
                    w_idx_d    = r_idx + row_t'(1);
                    w_boundary = (r_idx == row_t'(MATRIX_ROWS - 1));
                end
            end
            default: begin
                w_state_d = SCAN;
            end
        endcase
`else
        w_state_d = SCAN;
        if (w_tc) begin
            w_idx_d    = r_idx + row_t'(1);
            w_boundary = (r_idx == row_t'(MATRIX_ROWS - 1));
        end
`endif
    end

    assign w_swap = w_boundary & (r_pending | swap_req);

    // Output decode of the current phase; registered below so the pins show
    // the phase the state machine is in at each edge.
    always_comb begin
        w_row = 8'hFF;
        w_col = 8'h00;
        w_fs  = 1'b0;
        if (r_state == SCAN) begin
            w_row = ~(8'b1 << r_idx);
            w_col = r_front[r_idx];
            w_fs  = (r_idx == '0) && (w_cnt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= SCAN;
            r_idx         <= '0;
            r_pending     <= 1'b0;
            r_ack_pend    <= 1'b0;
            r_row         <= 8'hFF;
            r_col         <= 8'h00;
            r_frame_start <= 1'b0;
            r_swap_ack    <= 1'b0;
            for (int i = 0; i < MATRIX_ROWS; i++) begin
                r_back[i]  <= '0;
                r_front[i] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            if (wr_en) begin
                r_back[wr_addr] <= wr_data;
            end
            // Non-blocking copy takes back as it was before any same-cycle write.
            if (w_swap) begin
                for (int i = 0; i < MATRIX_ROWS; i++) begin
                    r_front[i] <= r_back[i];
                end
            end
            r_pending     <= w_boundary ? 1'b0 : (r_pending | swap_req);
            // Ack is held one cycle so it lines up with the next frame_start.
            r_ack_pend    <= w_swap;
            r_swap_ack    <= r_ack_pend;
            r_row         <= w_row;
            r_col         <= w_col;
            r_frame_start <= w_fs;
        end
    end

    assign row         = r_row;
    assign col         = r_col;
    assign frame_start = r_frame_start;
    assign swap_ack    = r_swap_ack;
    assign low         = 1'b0;

endmodule

// File: tb/tb_matrix_scan.sv
module tb_matrix_scan;

    localparam int unsigned RC = 4;
    localparam int unsigned BC = 2;
`ifdef MATRIX_SCAN_BLANK_EN
    localparam int SLOT = RC + BC;
`else
    localparam int SLOT = RC;
`endif
    localparam int P = 8 * SLOT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic       frame_start;
    logic [7:0] row;
    logic [7:0] col;
    logic       low;

    matrix_scan #(
        .ROW_CYCLES   (RC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .row         (row),
        .col         (col),
        .low         (low)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;   // edges since reset release; next edge sees phase k
    int n_ack   = 0;   // swap_ack pulses observed
    int ack_base;

    logic [7:0]  bk [8];
    logic [7:0]  fr [8];
    logic        pend;
    logic [63:0] sb [$];  // frames expected to appear at the next frame_start

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            bk[i] = '0;
            fr[i] = '0;
        end
        pend = 1'b0;
        sb.delete();
        k = 0;
    endtask

    // Check outputs showing phase q against the bench's frame model.
    task automatic check_phase(input int q);
        int s, r, off;
        logic       blank, exp_ack;
        logic [63:0] f;
        logic [7:0] er, ec;
        s = q % P;
        r = s / SLOT;
        off = s % SLOT;
        blank = (off >= RC);
        exp_ack = 1'b0;
        if (s == 0 && sb.size() != 0) begin
            exp_ack = 1'b1;
            f = sb.pop_front();
            for (int i = 0; i < 8; i++) fr[i] = f[8*i +: 8];
        end
        er = blank ? 8'hFF : ~(8'h01 << r);
        ec = blank ? 8'h00 : fr[r];
        chk("row", row, er);
        chk("col", col, ec);
        chk("frame_start", {7'b0, frame_start}, {7'b0, (s == 0)});
        chk("swap_ack", {7'b0, swap_ack}, {7'b0, exp_ack});
        chk("low", {7'b0, low}, 8'h00);
    endtask

    task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic sreq);
        logic bnd;
        logic [63:0] f;
        wr_en = we;
        wr_addr = wa;
        wr_data = wd;
        swap_req = sreq;
        bnd = ((k % P) == P - 1);
        if (bnd) begin
            if (pend || sreq) begin
                for (int i = 0; i < 8; i++) f[8*i +: 8] = bk[i];
                sb.push_back(f);
            end
            pend = 1'b0;
        end else begin
            pend = pend | sreq;
        end
        if (we) bk[wa] = wd;
        @(posedge clk);
        k++;
        @(negedge clk);
        if (swap_ack) n_ack++;
        check_phase(k - 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic run_to_slot(input int t);
        while ((k % P) != t) step(1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        wr_en = 1'b0;
        swap_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_row", row, 8'hFF);
            chk("rst_col", col, 8'h00);
            chk("rst_fs", {7'b0, frame_start}, 8'h00);
            chk("rst_ack", {7'b0, swap_ack}, 8'h00);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset(3);

        // Idle frames: first cycle shows FE with frame_start, period P.
        idle(2 * P);

        // Single row swap requested mid-frame.
        ack_base = n_ack;
        run_to_slot(10);
        step(1'b1, 3'd3, 8'hA5, 1'b0);
        step(1'b0, 3'd0, 8'h00, 1'b1);
        run_to_slot(0);
        idle(P);
        chk("ack_count_single", 8'(n_ack - ack_base), 8'd1);

        // Write without swap leaves the display untouched.
        ack_base = n_ack;
        step(1'b1, 3'd0, 8'hFF, 1'b0);
        idle(3 * P);
        chk("ack_count_noswap", 8'(n_ack - ack_base), 8'd0);

        // swap_req held for three frames, back[1] rewritten each frame.
        run_to_slot(0);
        ack_base = n_ack;
        for (int f = 0; f < 3; f++) begin
            while ((k % P) != 5) step(1'b0, 3'd0, 8'h00, 1'b1);
            step(1'b1, 3'd1, 8'h10 + 8'(f), 1'b1);
            while ((k % P) != 0) step(1'b0, 3'd0, 8'h00, 1'b1);
        end
        idle(1);
        chk("ack_count_held", 8'(n_ack - ack_base), 8'd3);
        idle(P);

        // Write on the boundary cycle with a swap pending.
        run_to_slot(10);
        step(1'b0, 3'd0, 8'h00, 1'b1);
        run_to_slot(P - 1);
        step(1'b1, 3'd2, 8'h3C, 1'b0);
        idle(P);
        step(1'b0, 3'd0, 8'h00, 1'b1);
        run_to_slot(0);
        idle(P);

        // Reset just before a pending swap would complete.
        run_to_slot(8);
        step(1'b1, 3'd5, 8'h77, 1'b1);
        run_to_slot(P - 2);
        ack_base = n_ack;
        do_reset(2);
        idle(2 * P);
        chk("ack_count_reset", 8'(n_ack - ack_base), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
